// File: rtl/emu_io_pkg.sv
// Shared types and layout helpers for the emulation I/O bridge.
package emu_io_pkg;

  localparam int HEX_SEG_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Lowest bit of digit i inside the packed snapshot (LEDs occupy the bottom).
  function automatic int hex_lo(input int led_w, input int i);
    return led_w + HEX_SEG_W * i;
  endfunction

  // Highest bit of digit i inside the packed snapshot.
  function automatic int hex_hi(input int led_w, input int i);
    return led_w + HEX_SEG_W * (i + 1) - 1;
  endfunction

endpackage

// File: rtl/emu_change_detector.sv
// Watches a W-bit bus, pulses on any cycle-to-cycle change and counts changes.
module emu_change_detector #(
  parameter int W = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [W-1:0]  i_sample,
  output logic          o_evt_valid,
  output logic [15:0]   o_evt_count
);

  logic [W-1:0] r_last;
  logic         r_evt;
  logic [15:0]  r_cnt;

  // Track previous sample and flag a difference one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= '0;
      r_evt  <= 1'b0;
    end else begin
      r_last <= i_sample;
      r_evt  <= (i_sample != r_last);
    end
  end

  // Count each pulse, holding at all-ones instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (r_evt && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_evt_valid = r_evt;
  assign o_evt_count = r_cnt;

endmodule

// File: rtl/emu_io_bridge.sv
// Host-to-board bridge: applies an input word, waits a settle time, returns
// a snapshot of LED/HEX outputs. A change monitor runs alongside.
//
// state     | meaning
// ST_IDLE   | ready for a host request
// ST_SETTLE | inputs applied, counting down the settle time
// ST_RESP   | snapshot held until the host takes it
module emu_io_bridge
  import emu_io_pkg::*;
#(
  parameter int SW_W   = 10,
  parameter int KEY_W  = 4,
  parameter int LED_W  = 10,
  parameter int HEX_N  = 6,
  parameter int SETTLE = 2
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [SW_W+KEY_W-1:0]              req_inputs,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [LED_W+HEX_SEG_W*HEX_N-1:0]   rsp_outputs,
  output logic                               rsp_changed,
  output logic [SW_W-1:0]                    SW,
  output logic [KEY_W-1:0]                   KEY,
  input  logic [LED_W-1:0]                   LED,
  input  logic [HEX_SEG_W*HEX_N-1:0]         HEX,
  output logic                               evt_valid,
  output logic [15:0]                        evt_count
);

  localparam int         OUT_W     = LED_W + HEX_SEG_W * HEX_N;
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_cnt;
  logic [SW_W-1:0]  r_sw;
  logic [KEY_W-1:0] r_key;
  logic [OUT_W-1:0] r_rsp_outputs;
  logic             r_rsp_changed;
  logic [OUT_W-1:0] w_sample;
  logic             w_accept;
  logic             w_capture;

  // Pack LEDs and digits into snapshot layout, digit 0 just above the LEDs.
  always_comb begin
    w_sample              = '0;
    w_sample[LED_W-1:0]   = LED;
    for (int i = 0; i < HEX_N; i++) begin
      w_sample[hex_lo(LED_W, i) +: HEX_SEG_W] = HEX[i*HEX_SEG_W +: HEX_SEG_W];
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == 8'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Input drive registers and settle countdown.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sw  <= '0;
      r_key <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_sw  <= req_inputs[SW_W-1:0];
      r_key <= req_inputs[SW_W+KEY_W-1:SW_W];
      r_cnt <= SETTLE_LD;
    end else if ((r_state == ST_SETTLE) && (r_cnt != 8'd0)) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  // Snapshot capture; the held snapshot doubles as the previous capture.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rsp_outputs <= '0;
      r_rsp_changed <= 1'b0;
    end else if (w_capture) begin
      r_rsp_outputs <= w_sample;
      r_rsp_changed <= (w_sample != r_rsp_outputs);
    end
  end

  assign SW          = r_sw;
  assign KEY         = r_key;
  assign rsp_outputs = r_rsp_outputs;
  assign rsp_changed = r_rsp_changed;

  emu_change_detector #(.W(OUT_W)) u_chg (
    .i_clk       (CLK),
    .i_rst_n     (RST_N),
    .i_sample    (w_sample),
    .o_evt_valid (evt_valid),
    .o_evt_count (evt_count)
  );

endmodule

// File: tb/tb_emu_io_bridge.sv
// Directed bench for emu_io_bridge: default and reduced-size instances.
module tb_emu_io_bridge;

  logic CLK;
  logic RST_N;

  // Instance 0: default parameters
  logic        req_valid0, req_ready0, rsp_valid0, rsp_ready0, rsp_changed0;
  logic [13:0] req_inputs0;
  logic [51:0] rsp_outputs0;
  logic [9:0]  SW0;
  logic [3:0]  KEY0;
  logic [9:0]  LED0;
  logic [41:0] hex0;
  logic        evt_valid0;
  logic [15:0] evt_count0;
  logic        tog;

  // Instance 1: SW_W=4, KEY_W=2, LED_W=8, HEX_N=2, SETTLE=5
  logic        req_valid1, req_ready1, rsp_valid1, rsp_ready1, rsp_changed1;
  logic [5:0]  req_inputs1;
  logic [21:0] rsp_outputs1;
  logic [3:0]  SW1;
  logic [1:0]  KEY1;
  logic [7:0]  LED1;
  logic [13:0] hex1;
  logic        evt_valid1;
  logic [15:0] evt_count1;

  typedef struct {
    logic [63:0] outp;
    logic        chg;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] prev0, prev1, held;
  int          checks, errors;

  assign LED0 = SW0 ^ {9'b0, tog};
  assign LED1 = {4'b0, SW1};
  assign hex1 = {7'h79, 7'h40};

  emu_io_bridge dut0 (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_inputs(req_inputs0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_outputs(rsp_outputs0),
    .rsp_changed(rsp_changed0), .SW(SW0), .KEY(KEY0), .LED(LED0), .HEX(hex0),
    .evt_valid(evt_valid0), .evt_count(evt_count0)
  );

  emu_io_bridge #(.SW_W(4), .KEY_W(2), .LED_W(8), .HEX_N(2), .SETTLE(5)) dut1 (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_inputs(req_inputs1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_outputs(rsp_outputs1),
    .rsp_changed(rsp_changed1), .SW(SW1), .KEY(KEY1), .LED(LED1), .HEX(hex1),
    .evt_valid(evt_valid1), .evt_count(evt_count1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one request, push its expected snapshot, confirm acceptance.
  task automatic drive_req(input int sel, input logic [13:0] v);
    exp_t e;
    @(negedge CLK);
    if (sel == 0) begin
      req_valid0  = 1'b1;
      req_inputs0 = v;
      e.outp = 64'({hex0, v[9:0] ^ {9'b0, tog}});
      e.chg  = (e.outp != prev0);
      prev0  = e.outp;
    end else begin
      req_valid1  = 1'b1;
      req_inputs1 = v[5:0];
      e.outp = 64'({7'h79, 7'h40, 4'h0, v[3:0]});
      e.chg  = (e.outp != prev1);
      prev1  = e.outp;
    end
    sb.push_back(e);
    @(posedge CLK); #1;
    if (sel == 0) begin
      chk("sw_after_accept", 64'(SW0), 64'(v[9:0]));
      chk("key_after_accept", 64'(KEY0), 64'(v[13:10]));
      req_valid0 = 1'b0;
    end else begin
      chk("sw1_after_accept", 64'(SW1), 64'(v[3:0]));
      chk("key1_after_accept", 64'(KEY1), 64'(v[5:4]));
      req_valid1 = 1'b0;
    end
  endtask

  // Called at accept edge +1: measure latency, then score the snapshot.
  task automatic wait_rsp(input int sel, input int settle);
    int   cyc;
    exp_t e;
    cyc = 0;
    do begin
      @(posedge CLK); #1;
      cyc++;
    end while ((((sel == 0) ? rsp_valid0 : rsp_valid1) == 1'b0) && (cyc < 40));
    chk("latency", 64'(cyc), 64'(settle));
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1 entries");
    end else begin
      e = sb.pop_front();
      held = e.outp;
      chk("rsp_outputs", (sel == 0) ? 64'(rsp_outputs0) : 64'(rsp_outputs1), e.outp);
      chk("rsp_changed", 64'((sel == 0) ? rsp_changed0 : rsp_changed1), 64'(e.chg));
    end
  endtask

  task automatic finish_rsp(input int sel);
    if (sel == 0) rsp_ready0 = 1'b1; else rsp_ready1 = 1'b1;
    @(posedge CLK); #1;
    chk("rsp_valid_drop", 64'((sel == 0) ? rsp_valid0 : rsp_valid1), 64'(0));
    chk("req_ready_rise", 64'((sel == 0) ? req_ready0 : req_ready1), 64'(1));
    rsp_ready0 = 1'b0;
    rsp_ready1 = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    prev0 = '0; prev1 = '0; held = '0;
    RST_N = 1'b0; tog = 1'b0; hex0 = '0;
    req_valid0 = 0; req_inputs0 = '0; rsp_ready0 = 0;
    req_valid1 = 0; req_inputs1 = '0; rsp_ready1 = 0;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("rst_req_ready", 64'(req_ready0), 64'(1));
    chk("rst_rsp_valid", 64'(rsp_valid0), 64'(0));
    chk("rst_sw", 64'(SW0), 64'(0));
    chk("rst_key", 64'(KEY0), 64'(0));
    chk("rst_rsp_outputs", 64'(rsp_outputs0), 64'(0));
    chk("rst_rsp_changed", 64'(rsp_changed0), 64'(0));
    chk("rst_evt_valid", 64'(evt_valid0), 64'(0));
    chk("first_sample_evt1", 64'(evt_valid1), 64'(1));
    repeat (2) @(posedge CLK); #1;
    chk("rst_evt_count", 64'(evt_count0), 64'(0));
    chk("first_sample_count1", 64'(evt_count1), 64'(1));

    // Default request, then identical repeat, then a differing one
    drive_req(0, 14'h0005); wait_rsp(0, 2); finish_rsp(0);
    drive_req(0, 14'h0005); wait_rsp(0, 2); finish_rsp(0);
    hex0 = {7'h06, 35'h0, 7'h3F};
    drive_req(0, 14'h2AAA); wait_rsp(0, 2); finish_rsp(0);

    // Backpressure: response held, competing request refused
    drive_req(0, 14'h1123); wait_rsp(0, 2);
    req_valid0 = 1'b1; req_inputs0 = 14'h0377;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      chk("bp_rsp_valid", 64'(rsp_valid0), 64'(1));
      chk("bp_req_ready", 64'(req_ready0), 64'(0));
      chk("bp_rsp_outputs", 64'(rsp_outputs0), held);
      chk("bp_sw_held", 64'(SW0), 64'(10'h123));
    end
    rsp_ready0 = 1'b1;
    @(posedge CLK); #1;
    chk("bp_hs_rsp_valid", 64'(rsp_valid0), 64'(0));
    chk("bp_hs_req_ready", 64'(req_ready0), 64'(1));
    chk("bp_hs_sw", 64'(SW0), 64'(10'h123));
    begin
      exp_t e;
      e.outp = 64'({hex0, 10'h377 ^ {9'b0, tog}});
      e.chg  = (e.outp != prev0);
      prev0  = e.outp;
      sb.push_back(e);
    end
    rsp_ready0 = 1'b0;
    @(posedge CLK); #1;
    chk("bp_next_accept_sw", 64'(SW0), 64'(10'h377));
    chk("bp_next_accept_key", 64'(KEY0), 64'(4'h0));
    req_valid0 = 1'b0;
    wait_rsp(0, 2); finish_rsp(0);

    // Reduced-size instance
    drive_req(1, 14'h002A); wait_rsp(1, 5);
    chk("hex1_field", 64'(rsp_outputs1[21:15]), 64'(7'h79));
    finish_rsp(1);

    // Reset in the middle of SETTLE
    hex0 = '0;
    drive_req(0, 14'h3FFF);
    RST_N = 1'b0;
    #1;
    chk("midrst_sw", 64'(SW0), 64'(0));
    chk("midrst_key", 64'(KEY0), 64'(0));
    chk("midrst_evt_count", 64'(evt_count0), 64'(0));
    sb.delete();
    prev0 = '0; prev1 = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST_N = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      chk("midrst_no_rsp", 64'(rsp_valid0), 64'(0));
      chk("midrst_req_ready", 64'(req_ready0), 64'(1));
    end

    // Monitor: five consecutive changes
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); tog = ~tog;
      @(posedge CLK); #1;
      chk("evt_pulse", 64'(evt_valid0), 64'(1));
    end
    @(posedge CLK); #1;
    chk("evt_after_burst", 64'(evt_valid0), 64'(0));
    chk("evt_count_5", 64'(evt_count0), 64'(5));

    // Monitor: saturation
    repeat (65600) begin
      @(negedge CLK); tog = ~tog;
    end
    repeat (3) @(posedge CLK); #1;
    chk("evt_count_sat", 64'(evt_count0), 64'(16'hFFFF));
    chk("evt_idle_after_sat", 64'(evt_valid0), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
